// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// The clog2 helpers match the ones used by the downstream fifo so widths line up.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Never returns zero, so a width derived from it is always legal.
    function automatic int clog2s(input int value);
        return (value < 2) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after the last winner,
// found by rotating a doubled request vector and priority-encoding the lowest set bit.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int C_NUM_REQ = 4,
    parameter int IDX_W     = clog2s(C_NUM_REQ)
) (
    input  logic [C_NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [C_NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    logic [2*C_NUM_REQ-1:0] req_dbl;
    logic [C_NUM_REQ-1:0]   req_rot;
    int                     offset;
    int                     sel;
    int                     pos;

    always_comb begin
        req_dbl = {req, req};
        offset  = int'(ptr) + 1;
        req_rot = C_NUM_REQ'(req_dbl >> offset);
        sel     = 0;
        any     = 1'b0;
        // Descending scan so the lowest rotated position wins.
        for (int j = C_NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                sel = j;
                any = 1'b1;
            end
        end
        pos = offset + sel;
        if (pos >= C_NUM_REQ) begin
            pos = pos - C_NUM_REQ;
        end
        winner = '0;
        if (any) begin
            winner[pos] = 1'b1;
        end
        idx = IDX_W'(pos);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one fifo write port among several producers,
// with a beat-count watchdog that forcibly ends over-long grants.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int C_WIDTH     = 32,
    parameter int C_NUM_REQ   = 4,
    parameter int C_MAX_BURST = 256
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [C_NUM_REQ*C_WIDTH-1:0]   REQ_DATA,
    input  logic [C_NUM_REQ-1:0]           REQ_VALID,
    input  logic [C_NUM_REQ-1:0]           REQ_LAST,
    output logic [C_NUM_REQ-1:0]           REQ_READY,
    output logic [C_WIDTH-1:0]             FIFO_WR_DATA,
    output logic                           FIFO_WR_VALID,
    input  logic                           FIFO_WR_READY,
    output logic [C_NUM_REQ-1:0]           GRANT,
    output logic [clog2s(C_NUM_REQ)-1:0]   GRANT_IDX,
    output logic                           ERR_OVERRUN
);

    localparam int IDX_W = clog2s(C_NUM_REQ);
    localparam int CNT_W = clog2s(C_MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(C_MAX_BURST - 1);
    localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(C_NUM_REQ - 1);

    state_t               state;
    state_t               state_nxt;
    logic [C_NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 err_overrun;

    logic [C_NUM_REQ-1:0] pick_winner;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic                 owner_valid;
    logic                 owner_last;
    logic                 xfer;
    logic                 at_limit;
    logic                 release_beat;
    logic                 overrun;

    fifo_wr_arbiter_rr_pick #(
        .C_NUM_REQ (C_NUM_REQ),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req    (REQ_VALID),
        .ptr    (ptr),
        .winner (pick_winner),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant is one-hot while BUSY, so masking by it selects the owner's signals.
    always_comb begin
        owner_valid  = |(REQ_VALID & grant);
        owner_last   = |(REQ_LAST & grant);
        FIFO_WR_DATA = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (grant[i]) begin
                FIFO_WR_DATA = REQ_DATA[i*C_WIDTH +: C_WIDTH];
            end
        end
        FIFO_WR_VALID = (state == BUSY) && owner_valid;
        REQ_READY     = (state == BUSY) ? (grant & {C_NUM_REQ{FIFO_WR_READY}}) : '0;
        xfer          = FIFO_WR_VALID && FIFO_WR_READY;
        at_limit      = (beat_cnt == CNT_LIMIT);
        release_beat  = xfer && (owner_last || at_limit);
        overrun       = xfer && at_limit && !owner_last;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_any) state_nxt = BUSY;
            BUSY: if (release_beat) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            grant       <= '0;
            grant_idx   <= '0;
            ptr         <= PTR_INIT;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= overrun;
            if (state == IDLE) begin
                if (pick_any) begin
                    grant     <= pick_winner;
                    grant_idx <= pick_idx;
                    ptr       <= pick_idx;
                    beat_cnt  <= '0;
                end
            end else if (xfer) begin
                // Release happens at the limit, so the counter can never wrap.
                if (release_beat) begin
                    grant <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign GRANT       = grant;
    assign GRANT_IDX   = grant_idx;
    assign ERR_OVERRUN = err_overrun;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: four requesters, watchdog limit of eight beats.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] req_data;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic [31:0]  fifo_wr_data;
    logic         fifo_wr_valid;
    logic         fifo_wr_ready;
    logic [3:0]   grant;
    logic [1:0]   grant_idx;
    logic         err_overrun;

    int vecs  = 0;
    int fails = 0;

    logic [3:0]  rr_grant [10];
    logic [1:0]  rr_idx   [10];
    logic        bp_rdy   [6];
    logic [31:0] bp_data  [6];
    logic        bp_last  [6];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .C_WIDTH     (32),
        .C_NUM_REQ   (4),
        .C_MAX_BURST (8)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .REQ_DATA      (req_data),
        .REQ_VALID     (req_valid),
        .REQ_LAST      (req_last),
        .REQ_READY     (req_ready),
        .FIFO_WR_DATA  (fifo_wr_data),
        .FIFO_WR_VALID (fifo_wr_valid),
        .FIFO_WR_READY (fifo_wr_ready),
        .GRANT         (grant),
        .GRANT_IDX     (grant_idx),
        .ERR_OVERRUN   (err_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        req_data[i*32 +: 32] = v;
    endtask

    initial begin
        rr_grant = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                     4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rr_idx   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
        bp_rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_data  = '{32'h30, 32'h31, 32'h31, 32'h31, 32'h32, 32'h33};
        bp_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        req_data = '0;
        req_valid = '0;
        req_last = '0;
        fifo_wr_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_idx", grant_idx, 2'd0);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_valid", fifo_wr_valid, 1'b0);
        chk("rst_err", err_overrun, 1'b0);

        // Round-robin from reset: single-beat packets on all four requesters
        next_cycle();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_last = 4'b1111;
        fifo_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + i);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            chk("rr_grant", grant, rr_grant[k]);
            chk("rr_ready", req_ready, rr_grant[k]);
            if (rr_grant[k] != 4'b0000) begin
                chk("rr_idx", grant_idx, rr_idx[k]);
                chk("rr_data", fifo_wr_data, 32'hA0 + rr_idx[k]);
            end
        end
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rr_end", grant, 4'b0000);

        // Packet atomicity: req1 sends five beats while req2 waits
        next_cycle();
        req_valid = 4'b0110;
        req_last = 4'b0100;
        set_data(1, 32'h10);
        set_data(2, 32'h22);
        @(negedge clk);
        chk("pk_idle", grant, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            set_data(1, 32'h10 + k);
            req_last[1] = (k == 4);
            @(negedge clk);
            chk("pk_grant", grant, 4'b0010);
            chk("pk_valid", fifo_wr_valid, 1'b1);
            chk("pk_data", fifo_wr_data, 32'h10 + k);
        end
        next_cycle();
        req_valid[1] = 1'b0;
        req_last[1] = 1'b0;
        @(negedge clk);
        chk("pk_gap", grant, 4'b0000);
        next_cycle();
        @(negedge clk);
        chk("pk_next_grant", grant, 4'b0100);
        chk("pk_next_idx", grant_idx, 2'd2);
        chk("pk_next_data", fifo_wr_data, 32'h22);
        next_cycle();
        req_valid = 4'b0000;
        req_last = 4'b0000;
        @(negedge clk);
        chk("pk_end", grant, 4'b0000);

        // Backpressure on a four-beat packet from req3
        next_cycle();
        req_valid = 4'b1000;
        set_data(3, 32'h30);
        @(negedge clk);
        chk("bp_idle", grant, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            fifo_wr_ready = bp_rdy[k];
            set_data(3, bp_data[k]);
            req_last[3] = bp_last[k];
            @(negedge clk);
            chk("bp_grant", grant, 4'b1000);
            chk("bp_valid", fifo_wr_valid, 1'b1);
            chk("bp_data", fifo_wr_data, bp_data[k]);
            chk("bp_ready", req_ready, bp_rdy[k] ? 4'b1000 : 4'b0000);
        end
        next_cycle();
        req_valid = 4'b0000;
        req_last = 4'b0000;
        fifo_wr_ready = 1'b1;
        @(negedge clk);
        chk("bp_end", grant, 4'b0000);

        // Watchdog: req0 streams without LAST, req1 waits with a single beat
        next_cycle();
        req_valid = 4'b0011;
        req_last = 4'b0010;
        set_data(0, 32'h100);
        set_data(1, 32'h41);
        @(negedge clk);
        chk("wd_idle", grant, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            set_data(0, 32'h100 + k);
            @(negedge clk);
            chk("wd_grant", grant, 4'b0001);
            chk("wd_data", fifo_wr_data, 32'h100 + k);
            chk("wd_err_low", err_overrun, 1'b0);
        end
        next_cycle();
        set_data(0, 32'h108);
        @(negedge clk);
        chk("wd_err_pulse", err_overrun, 1'b1);
        chk("wd_released", grant, 4'b0000);
        next_cycle();
        @(negedge clk);
        chk("wd_err_clear", err_overrun, 1'b0);
        chk("wd_req1_grant", grant, 4'b0010);
        chk("wd_req1_data", fifo_wr_data, 32'h41);
        next_cycle();
        @(negedge clk);
        chk("wd_gap", grant, 4'b0000);
        next_cycle();
        @(negedge clk);
        chk("wd_regrant", grant, 4'b0001);
        chk("wd_regrant_data", fifo_wr_data, 32'h108);
        next_cycle();
        set_data(0, 32'h109);
        @(negedge clk);
        chk("wd_cnt_cleared", err_overrun, 1'b0);
        chk("wd_hold", grant, 4'b0001);
        next_cycle();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("wd_no_err", err_overrun, 1'b0);
        chk("wd_stall_hold", grant, 4'b0001);
        next_cycle();
        rst = 1'b1;
        req_valid = 4'b0000;
        req_last = 4'b0000;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("wd_rst", grant, 4'b0000);

        // LAST coinciding with the watchdog limit is a normal release
        next_cycle();
        req_valid = 4'b0001;
        set_data(0, 32'h200);
        @(negedge clk);
        chk("l8_idle", grant, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            set_data(0, 32'h200 + k);
            req_last[0] = (k == 7);
            @(negedge clk);
            chk("l8_grant", grant, 4'b0001);
            chk("l8_data", fifo_wr_data, 32'h200 + k);
        end
        next_cycle();
        req_valid = 4'b0000;
        req_last = 4'b0000;
        @(negedge clk);
        chk("l8_no_err", err_overrun, 1'b0);
        chk("l8_released", grant, 4'b0000);

        // Reset in the middle of a six-beat packet from req2
        next_cycle();
        req_valid = 4'b0100;
        set_data(2, 32'h60);
        @(negedge clk);
        chk("rm_idle", grant, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            set_data(2, 32'h60 + k);
            @(negedge clk);
            chk("rm_grant", grant, 4'b0100);
            chk("rm_data", fifo_wr_data, 32'h60 + k);
        end
        next_cycle();
        rst = 1'b1;
        req_valid = 4'b1101;
        set_data(2, 32'h63);
        @(negedge clk);
        chk("rm_pre_rst", grant, 4'b0100);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rm_grant_drop", grant, 4'b0000);
        chk("rm_valid_drop", fifo_wr_valid, 1'b0);
        chk("rm_ready_drop", req_ready, 4'b0000);
        chk("rm_idx_rst", grant_idx, 2'd0);
        next_cycle();
        req_last = 4'b0001;
        set_data(0, 32'h70);
        @(negedge clk);
        chk("rm_first_win", grant, 4'b0001);
        chk("rm_first_idx", grant_idx, 2'd0);
        chk("rm_first_data", fifo_wr_data, 32'h70);
        next_cycle();
        req_valid = 4'b0000;
        req_last = 4'b0000;
        @(negedge clk);
        chk("rm_end", grant, 4'b0000);

        // Owner stall: req2 goes quiet for 20 cycles while req0 waits
        next_cycle();
        req_valid = 4'b0100;
        set_data(2, 32'h50);
        @(negedge clk);
        chk("st_idle", grant, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            set_data(2, 32'h50 + k);
            @(negedge clk);
            chk("st_grant", grant, 4'b0100);
            chk("st_data", fifo_wr_data, 32'h50 + k);
        end
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            if (k == 0) begin
                req_valid = 4'b0001;
                set_data(2, 32'h52);
            end
            @(negedge clk);
            chk("st_hold", grant, 4'b0100);
            chk("st_no_xfer", fifo_wr_valid, 1'b0);
            chk("st_no_err", err_overrun, 1'b0);
            chk("st_ready", req_ready, 4'b0100);
        end
        next_cycle();
        req_valid = 4'b0101;
        req_last = 4'b0100;
        @(negedge clk);
        chk("st_resume_valid", fifo_wr_valid, 1'b1);
        chk("st_resume_data", fifo_wr_data, 32'h52);
        next_cycle();
        req_valid = 4'b0001;
        req_last = 4'b0000;
        @(negedge clk);
        chk("st_gap", grant, 4'b0000);
        next_cycle();
        @(negedge clk);
        chk("st_req0_grant", grant, 4'b0001);
        chk("st_req0_idx", grant_idx, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
